// File: rtl/ac_ph_accum_if.sv
// Polar-result input stream and averaged-result output stream for ac_ph_accum.
// The slave modport is the accumulator's view; master is the producer/consumer side.
interface ac_ph_accum_if #(
  parameter int CHANNELS  = 4,
  parameter int MAG_WIDTH = 32,
  parameter int PH_WIDTH  = 32
);
  localparam int CH_W = $clog2(CHANNELS);

  logic                       i_vld;
  logic                       i_rdy;
  logic [CH_W-1:0]            i_ch;
  logic [MAG_WIDTH-1:0]       i_mag;
  logic signed [PH_WIDTH-1:0] i_phase;

  logic                       o_vld;
  logic                       o_rdy;
  logic [CH_W-1:0]            o_ch;
  logic [MAG_WIDTH-1:0]       o_ac;
  logic signed [PH_WIDTH-1:0] o_ph;
  logic                       o_last;

  modport slave (
    input  i_vld, i_ch, i_mag, i_phase, o_rdy,
    output i_rdy, o_vld, o_ch, o_ac, o_ph, o_last
  );

  modport master (
    output i_vld, i_ch, i_mag, i_phase, o_rdy,
    input  i_rdy, o_vld, o_ch, o_ac, o_ph, o_last
  );
endinterface

// File: rtl/ac_ph_accum.sv
// Collects one polar result per channel per frame, accumulates magnitude and phase
// relative to a reference channel over 2^AVG_LOG frames, then streams the averages.
module ac_ph_accum #(
  parameter int CHANNELS  = 4,
  parameter int MAG_WIDTH = 32,
  parameter int PH_WIDTH  = 32,
  parameter int AVG_LOG   = 2,
  parameter int REF_CH    = 0,
  parameter int PI_CODE   = 843314857
) (
  input  logic         clk,
  input  logic         rst,
  ac_ph_accum_if.slave bus,
  output logic         frame_done,
  output logic         err_seq
);
  localparam int CH_W = $clog2(CHANNELS);
  localparam int MA_W = MAG_WIDTH + AVG_LOG;
  localparam int PA_W = PH_WIDTH + AVG_LOG;
  localparam logic [CH_W-1:0]           LAST_CH  = CH_W'(CHANNELS - 1);
  localparam logic [AVG_LOG:0]          FRAMES   = (AVG_LOG + 1)'(1 << AVG_LOG);
  localparam logic signed [PH_WIDTH:0]  PI_W     = (PH_WIDTH + 1)'(PI_CODE);
  localparam logic signed [PH_WIDTH:0]  TWO_PI_W = PI_W + PI_W;

  // Fold a raw phase difference back into [-pi, pi) with a single correction.
  function automatic logic signed [PH_WIDTH:0] wrap_phase(input logic signed [PH_WIDTH:0] d);
    if (d >= PI_W) return d - TWO_PI_W;
    if (d < -PI_W) return d + TWO_PI_W;
    return d;
  endfunction

  function automatic logic signed [PA_W-1:0] add_phase(input logic signed [PA_W-1:0] acc,
                                                        input logic signed [PH_WIDTH:0] d);
    return acc + PA_W'(d);
  endfunction

  function automatic logic [MAG_WIDTH-1:0] avg_mag(input logic [MA_W-1:0] acc);
    return MAG_WIDTH'(acc >> AVG_LOG);
  endfunction

  function automatic logic signed [PH_WIDTH-1:0] avg_phase(input logic signed [PA_W-1:0] acc);
    return PH_WIDTH'(acc >>> AVG_LOG);
  endfunction

  typedef enum logic [1:0] {COLLECT, ACCUM, OUTPUT} state_t;

  state_t                     state, state_nxt;
  logic [CH_W-1:0]            exp_idx, acc_idx, out_idx;
  logic [AVG_LOG:0]           frame_cnt;
  logic [MAG_WIDTH-1:0]       mag_rf [CHANNELS];
  logic signed [PH_WIDTH-1:0] ph_rf  [CHANNELS];
  logic [MA_W-1:0]            mag_acc [CHANNELS];
  logic signed [PA_W-1:0]     ph_acc  [CHANNELS];
  logic                       in_fire, in_match, in_store;
  logic                       out_fire, out_done, accum_last;
  logic signed [PH_WIDTH:0]   diff_p0;

  assign in_fire    = bus.i_vld && bus.i_rdy;
  assign in_match   = bus.i_ch == exp_idx;
  assign in_store   = in_fire && (in_match || bus.i_ch == '0);
  assign out_fire   = bus.o_vld && bus.o_rdy;
  assign out_done   = out_fire && out_idx == LAST_CH;
  assign accum_last = state == ACCUM && acc_idx == LAST_CH;
  assign diff_p0    = wrap_phase((PH_WIDTH + 1)'(ph_rf[acc_idx]) - (PH_WIDTH + 1)'(ph_rf[REF_CH]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bus.i_rdy  = 1'b0;
    bus.o_vld  = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      COLLECT: begin
        bus.i_rdy = 1'b1;
        if (in_fire && in_match && exp_idx == LAST_CH) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (acc_idx == LAST_CH) begin
          frame_done = 1'b1;
          state_nxt  = (frame_cnt + (AVG_LOG + 1)'(1) == FRAMES) ? OUTPUT : COLLECT;
        end
      end
      OUTPUT: begin
        bus.o_vld = 1'b1;
        if (out_done) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Output beat is a pure function of registered state, so it holds under backpressure.
  assign bus.o_ch   = out_idx;
  assign bus.o_last = bus.o_vld && out_idx == LAST_CH;
  assign bus.o_ac   = avg_mag(mag_acc[out_idx]);
  assign bus.o_ph   = avg_phase(ph_acc[out_idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_idx   <= '0;
      acc_idx   <= '0;
      out_idx   <= '0;
      frame_cnt <= '0;
      err_seq   <= 1'b0;
    end else begin
      err_seq <= in_fire && !in_match;
      // An out-of-order channel 0 restarts the frame; any other stray waits for channel 0.
      if (in_fire) begin
        if (in_match) exp_idx <= (exp_idx == LAST_CH) ? '0 : exp_idx + CH_W'(1);
        else          exp_idx <= (bus.i_ch == '0) ? CH_W'(1) : '0;
      end
      if (state == ACCUM) acc_idx <= (acc_idx == LAST_CH) ? '0 : acc_idx + CH_W'(1);
      if (accum_last)    frame_cnt <= frame_cnt + (AVG_LOG + 1)'(1);
      else if (out_done) frame_cnt <= '0;
      if (out_fire) out_idx <= (out_idx == LAST_CH) ? '0 : out_idx + CH_W'(1);
    end
  end

  // Stage p0: per-channel frame capture.
  always_ff @(posedge clk) begin
    if (in_store) begin
      mag_rf[bus.i_ch] <= bus.i_mag;
      ph_rf[bus.i_ch]  <= bus.i_phase;
    end
  end

  // Stage p1: one channel accumulated per ACCUM cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < CHANNELS; k++) begin
        mag_acc[k] <= '0;
        ph_acc[k]  <= '0;
      end
    end else if (out_done) begin
      for (int k = 0; k < CHANNELS; k++) begin
        mag_acc[k] <= '0;
        ph_acc[k]  <= '0;
      end
    end else if (state == ACCUM) begin
      mag_acc[acc_idx] <= mag_acc[acc_idx] + MA_W'(mag_rf[acc_idx]);
      ph_acc[acc_idx]  <= add_phase(ph_acc[acc_idx], diff_p0);
    end
  end
endmodule

// File: tb/tb_ac_ph_accum.sv
// Bench for ac_ph_accum: directed vector table, sequence/backpressure/reset corner
// cases, and randomized frames checked against an arithmetic averaging model.
module tb_ac_ph_accum;
  localparam int     CH = 4;
  localparam int     AL = 1;
  localparam int     RC = 0;
  localparam longint PI = 843314857;

  logic clk = 1'b0;
  logic rst;
  logic frame_done, err_seq;

  ac_ph_accum_if #(.CHANNELS(CH), .MAG_WIDTH(32), .PH_WIDTH(32)) bus ();

  ac_ph_accum #(
    .CHANNELS(CH), .MAG_WIDTH(32), .PH_WIDTH(32), .AVG_LOG(AL),
    .REF_CH(RC), .PI_CODE(843314857)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .frame_done(frame_done), .err_seq(err_seq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Reference model: running sums of magnitudes and wrapped phase differences.
  longint m_mag[CH];
  longint m_ph[CH];

  task automatic model_clear();
    for (int k = 0; k < CH; k++) begin m_mag[k] = 0; m_ph[k] = 0; end
  endtask

  task automatic model_frame(input logic [31:0] mg[CH], input int ph[CH]);
    longint d;
    for (int k = 0; k < CH; k++) begin
      d = longint'(ph[k]) - longint'(ph[RC]);
      if (d >= PI) d = d - 2 * PI;
      else if (d < -PI) d = d + 2 * PI;
      m_mag[k] += longint'(mg[k]);
      m_ph[k]  += d;
    end
  endtask

  task automatic model_expect(output logic [31:0] eac[CH], output int eph[CH]);
    longint n, q;
    n = longint'(1) << AL;
    for (int k = 0; k < CH; k++) begin
      eac[k] = 32'(m_mag[k] / n);
      q = m_ph[k] / n;
      if ((m_ph[k] % n) != 0 && m_ph[k] < 0) q = q - 1;
      eph[k] = int'(q);
    end
  endtask

  task automatic send_beat(input int ch, input logic [31:0] mag, input int ph, input int gap);
    int budget;
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    bus.i_vld = 1'b1; bus.i_ch = 2'(ch); bus.i_mag = mag; bus.i_phase = ph;
    budget = 0;
    @(negedge clk);
    while (!bus.i_rdy && budget < 50) begin @(negedge clk); budget++; end
    if (!bus.i_rdy) chk("i_rdy_timeout", 0, 1);
    @(posedge clk); #1;
    bus.i_vld = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] mg[CH], input int ph[CH], input bit rnd_gap);
    for (int k = 0; k < CH; k++)
      send_beat(k, mg[k], ph[k], rnd_gap ? int'($urandom_range(0, 2)) : 0);
    model_frame(mg, ph);
  endtask

  // Called right after the last beat's accepting edge.
  task automatic frame_tail(input bit expect_out);
    bit ok;
    ok = 1'b1;
    for (int n = 1; n <= CH; n++) begin
      @(negedge clk);
      if (frame_done !== (n == CH)) ok = 1'b0;
    end
    chk("frame_done_timing", longint'(ok), 1);
    @(negedge clk);
    chk("post_frame_o_vld", longint'(bus.o_vld), longint'(expect_out));
    chk("post_frame_i_rdy", longint'(bus.i_rdy), longint'(!expect_out));
    @(posedge clk); #1;
  endtask

  task automatic recv_out(input logic [31:0] eac[CH], input int eph[CH], input int n_beats,
                          input int bp_beat, input int bp_len, input bit rnd_bp);
    int hold;
    bit ok;
    for (int k = 0; k < n_beats; k++) begin
      hold = (k == bp_beat) ? bp_len : (rnd_bp ? int'($urandom_range(0, 2)) : 0);
      if (hold > 0) begin
        bus.o_rdy = 1'b0;
        bus.i_vld = 1'b1; bus.i_ch = 2'd3;
        ok = 1'b1;
        for (int c = 0; c < hold; c++) begin
          @(negedge clk);
          if (bus.o_vld !== 1'b1 || bus.o_ch !== 2'(k) || bus.o_ac !== eac[k] ||
              bus.o_ph !== eph[k] || bus.o_last !== (k == CH - 1) ||
              bus.i_rdy !== 1'b0 || err_seq !== 1'b0) ok = 1'b0;
        end
        chk("hold_stable", longint'(ok), 1);
        @(posedge clk); #1;
        bus.i_vld = 1'b0;
      end
      bus.o_rdy = 1'b1;
      @(negedge clk);
      chk("o_vld",  longint'(bus.o_vld), 1);
      chk("o_ch",   longint'(bus.o_ch), longint'(k));
      chk("o_ac",   longint'(bus.o_ac), longint'(eac[k]));
      chk("o_ph",   longint'(bus.o_ph), longint'(eph[k]));
      chk("o_last", longint'(bus.o_last), longint'(k == CH - 1));
      @(posedge clk); #1;
      bus.o_rdy = 1'b0;
    end
    if (n_beats == CH) begin
      @(negedge clk);
      chk("after_last_o_vld", longint'(bus.o_vld), 0);
      chk("after_last_i_rdy", longint'(bus.i_rdy), 1);
    end
  endtask

  typedef struct {
    logic [31:0] mag0[CH];
    logic [31:0] mag1[CH];
    int          ph0[CH];
    int          ph1[CH];
    logic [31:0] ac[CH];
    int          oph[CH];
  } vec_t;

  vec_t        vt[6];
  logic [31:0] mg_a[CH], mg_b[CH], eac[CH];
  int          ph_a[CH], ph_b[CH], eph[CH];
  bit          ok;

  task automatic rand_frame(output logic [31:0] mg[CH], output int ph[CH]);
    for (int k = 0; k < CH; k++) begin
      mg[k] = $urandom;
      ph[k] = int'(longint'($urandom_range(0, 32'd1686629713)) - PI);
    end
  endtask

  initial begin
    bus.i_vld = 1'b0; bus.i_ch = '0; bus.i_mag = '0; bus.i_phase = '0; bus.o_rdy = 1'b0;
    rst = 1'b1;

    vt[0].mag0 = '{32'd10, 32'd20, 32'd30, 32'd40};  vt[0].mag1 = vt[0].mag0;
    vt[0].ph0  = '{100, 300, -50, 100};               vt[0].ph1  = vt[0].ph0;
    vt[0].ac   = '{32'd10, 32'd20, 32'd30, 32'd40};  vt[0].oph  = '{0, 200, -150, 0};

    vt[1].mag0 = '{32'd1, 32'd2, 32'd3, 32'd4};      vt[1].mag1 = vt[1].mag0;
    vt[1].ph0  = '{800000000, -800000000, 800000000, 800000000}; vt[1].ph1 = vt[1].ph0;
    vt[1].ac   = '{32'd1, 32'd2, 32'd3, 32'd4};      vt[1].oph  = '{0, 86629714, 0, 0};

    vt[2].mag0 = '{32'd1, 32'd2, 32'd3, 32'd4};      vt[2].mag1 = vt[2].mag0;
    vt[2].ph0  = '{-800000000, 800000000, -800000000, -800000000}; vt[2].ph1 = vt[2].ph0;
    vt[2].ac   = '{32'd1, 32'd2, 32'd3, 32'd4};      vt[2].oph  = '{0, -86629714, 0, 0};

    vt[3].mag0 = '{32'd1, 32'd7, 32'd100, 32'hFFFFFFFF};
    vt[3].mag1 = '{32'd2, 32'd8, 32'd101, 32'hFFFFFFFE};
    vt[3].ph0  = '{0, 5, 0, 0};                       vt[3].ph1  = '{0, -2, 0, 0};
    vt[3].ac   = '{32'd1, 32'd7, 32'd100, 32'hFFFFFFFE}; vt[3].oph = '{0, 1, 0, 0};

    vt[4].mag0 = '{32'd5, 32'd6, 32'd7, 32'd8};      vt[4].mag1 = '{32'd5, 32'd6, 32'd7, 32'd9};
    vt[4].ph0  = '{1000, 995, 1000, 1000};            vt[4].ph1  = '{-7, -5, -7, -7};
    vt[4].ac   = '{32'd5, 32'd6, 32'd7, 32'd8};      vt[4].oph  = '{0, -2, 0, 0};

    vt[5].mag0 = '{32'd0, 32'hFFFFFFFF, 32'd1, 32'd2}; vt[5].mag1 = vt[5].mag0;
    vt[5].ph0  = '{0, 843314857, -843314857, 843314856}; vt[5].ph1 = vt[5].ph0;
    vt[5].ac   = '{32'd0, 32'hFFFFFFFF, 32'd1, 32'd2};
    vt[5].oph  = '{0, -843314857, -843314857, 843314856};

    // Reset state
    @(posedge clk); #1;
    chk("rst_o_vld", longint'(bus.o_vld), 0);
    chk("rst_o_ch", longint'(bus.o_ch), 0);
    chk("rst_o_ac", longint'(bus.o_ac), 0);
    chk("rst_o_ph", longint'(bus.o_ph), 0);
    chk("rst_o_last", longint'(bus.o_last), 0);
    chk("rst_frame_done", longint'(frame_done), 0);
    chk("rst_err_seq", longint'(err_seq), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_release_i_rdy", longint'(bus.i_rdy), 1);

    // Directed vector table (backpressure on beat 1 of the first entry)
    model_clear();
    for (int v = 0; v < 6; v++) begin
      mg_a = vt[v].mag0; mg_b = vt[v].mag1; ph_a = vt[v].ph0; ph_b = vt[v].ph1;
      eac = vt[v].ac; eph = vt[v].oph;
      send_frame(mg_a, ph_a, 1'b0);
      frame_tail(1'b0);
      send_frame(mg_b, ph_b, 1'b0);
      frame_tail(1'b1);
      recv_out(eac, eph, CH, (v == 0) ? 1 : -1, 5, 1'b0);
    end

    // Out-of-order sequences
    model_clear();
    send_beat(0, 32'd11, 11, 0);
    send_beat(1, 32'd12, 12, 0);
    send_beat(3, 32'd13, 13, 0);
    @(negedge clk);
    chk("err_seq_on_ch3", longint'(err_seq), 1);
    ok = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (err_seq !== 1'b0 || frame_done !== 1'b0) ok = 1'b0;
    end
    chk("err_single_no_frame_done", longint'(ok), 1);
    rand_frame(mg_a, ph_a);
    send_frame(mg_a, ph_a, 1'b0);
    frame_tail(1'b0);
    rand_frame(mg_b, ph_b);
    send_beat(0, 32'd999, 999, 0);
    send_beat(1, 32'd998, 998, 0);
    send_beat(0, mg_b[0], ph_b[0], 0);
    @(negedge clk);
    chk("err_seq_on_restart", longint'(err_seq), 1);
    for (int k = 1; k < CH; k++) send_beat(k, mg_b[k], ph_b[k], 0);
    model_frame(mg_b, ph_b);
    frame_tail(1'b1);
    model_expect(eac, eph);
    recv_out(eac, eph, CH, -1, 0, 1'b0);

    // Reset while streaming output
    model_clear();
    rand_frame(mg_a, ph_a); send_frame(mg_a, ph_a, 1'b1); frame_tail(1'b0);
    rand_frame(mg_b, ph_b); send_frame(mg_b, ph_b, 1'b1); frame_tail(1'b1);
    model_expect(eac, eph);
    recv_out(eac, eph, 2, -1, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_o_vld", longint'(bus.o_vld), 0);
    chk("midrst_o_ch", longint'(bus.o_ch), 0);
    chk("midrst_o_ac", longint'(bus.o_ac), 0);
    chk("midrst_o_ph", longint'(bus.o_ph), 0);
    chk("midrst_o_last", longint'(bus.o_last), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_i_rdy", longint'(bus.i_rdy), 1);
    model_clear();
    rand_frame(mg_a, ph_a); send_frame(mg_a, ph_a, 1'b0); frame_tail(1'b0);
    rand_frame(mg_b, ph_b); send_frame(mg_b, ph_b, 1'b0); frame_tail(1'b1);
    model_expect(eac, eph);
    recv_out(eac, eph, CH, -1, 0, 1'b0);

    // Randomized frames with gaps and backpressure
    for (int it = 0; it < 8; it++) begin
      model_clear();
      rand_frame(mg_a, ph_a); send_frame(mg_a, ph_a, 1'b1); frame_tail(1'b0);
      rand_frame(mg_b, ph_b); send_frame(mg_b, ph_b, 1'b1); frame_tail(1'b1);
      model_expect(eac, eph);
      recv_out(eac, eph, CH, -1, 0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/ac_ph_accum.md
AC_PH_ACCUM -- requirements
Module: ac_ph_accum

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, meaning number of channels per frame (2..16).
REQ-002 The block SHALL have parameter MAG_WIDTH, default 32, meaning unsigned magnitude width.
REQ-003 The block SHALL have parameter PH_WIDTH, default 32, meaning signed phase width.
REQ-004 The block SHALL have parameter AVG_LOG, default 2, meaning 2^AVG_LOG frames are averaged (0..8).
REQ-005 The block SHALL have parameter REF_CH, default 0, meaning the reference channel index.
REQ-006 The block SHALL have parameter PI_CODE, default 843314857, meaning the phase code of +pi (pi*2^28).
REQ-007 The block SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-008 The block SHALL have port rst, input, 1, meaning reset, asynchronous and active-high.
REQ-009 The block SHALL have ports i_vld (in, 1), i_rdy (out, 1), i_ch (in, $clog2(CHANNELS)), i_mag (in, MAG_WIDTH), i_phase (in, PH_WIDTH, signed), meaning one polar result per accepted beat.
REQ-010 The block SHALL have ports o_vld (out, 1), o_rdy (in, 1), o_ch (out, $clog2(CHANNELS)), o_ac (out, MAG_WIDTH), o_ph (out, PH_WIDTH, signed), o_last (out, 1), meaning averaged result per channel.
REQ-011 The block SHALL have ports frame_done (out, 1) and err_seq (out, 1), meaning single-cycle status pulses.

Function
REQ-012 An input beat SHALL be accepted when i_vld and i_rdy are both high; an output beat SHALL complete when o_vld and o_rdy are both high.
REQ-013 The FSM SHALL have states COLLECT, ACCUM, OUTPUT; i_rdy SHALL be high only in COLLECT.
REQ-014 In COLLECT, beats SHALL arrive in order 0..CHANNELS-1, gaps allowed; each accepted beat SHALL store i_mag and i_phase in a per-channel register file.
REQ-015 An accepted beat with i_ch not equal to the expected index SHALL pulse err_seq for one cycle and discard the partial frame; if that i_ch is 0 it SHALL be stored as the start of a new frame, otherwise the block SHALL wait for i_ch=0.
REQ-016 Acceptance of channel CHANNELS-1 at cycle T SHALL enter ACCUM at T+1; ACCUM SHALL process one channel per cycle, cycles T+1..T+CHANNELS.
REQ-017 Per channel k, diff = phase[k] - phase[REF_CH] in PH_WIDTH+1 bits; if diff >= PI_CODE subtract 2*PI_CODE; if diff < -PI_CODE add 2*PI_CODE; result in [-PI_CODE, PI_CODE).
REQ-018 Accumulators SHALL be mag_acc[k] (unsigned, MAG_WIDTH+AVG_LOG) += mag[k] and ph_acc[k] (signed, PH_WIDTH+AVG_LOG) += diff; no overflow is possible at these widths.
REQ-019 frame_done SHALL pulse at cycle T+CHANNELS; the frame counter SHALL then increment.
REQ-020 If the counter has not reached 2^AVG_LOG, the FSM SHALL return to COLLECT with i_rdy high at T+CHANNELS+1.
REQ-021 If it has, the FSM SHALL enter OUTPUT with o_vld high at T+CHANNELS+1 and o_ch=0.
REQ-022 In OUTPUT, o_ac SHALL be mag_acc[o_ch] >> AVG_LOG (truncate) and o_ph SHALL be ph_acc[o_ch] arithmetically shifted right by AVG_LOG (floor), lower bits kept; o_ph for REF_CH SHALL be 0.
REQ-023 While o_vld high and o_rdy low, o_ch, o_ac, o_ph and o_last SHALL hold stable.
REQ-024 o_ch SHALL advance 0..CHANNELS-1 one per completed beat; o_last SHALL be high with o_ch=CHANNELS-1.
REQ-025 On completion of the o_last beat, accumulators and frame counter SHALL clear, o_vld SHALL drop and i_rdy SHALL rise on the next cycle.
REQ-026 i_vld while i_rdy is low SHALL be ignored with no error flagged.

Reset
REQ-027 On rst high, state SHALL go to COLLECT, expected index, frame counter and accumulators to 0, and o_vld, o_ch, o_ac, o_ph, o_last, frame_done, err_seq to 0 immediately; i_rdy SHALL be 1 from the first clock after rst falls.
REQ-028 Reset during any state SHALL abandon the frame and any pending output without producing output beats.

Verification
REQ-029 With CHANNELS=4, AVG_LOG=0, o_rdy=1: mags 10,20,30,40, phases 100,300,-50,100 -> frame_done at T+4, then o_ac 10,20,30,40, o_ph 0,200,-150,0, o_last on beat 3.
REQ-030 Wrap: ref phase 800000000, ch1 -800000000 -> o_ph[1]=86629714; ref -800000000, ch1 800000000 -> o_ph[1]=-86629714.
REQ-031 AVG_LOG=1: ch1 diffs 5 and -2, mags 7 and 8 -> o_ph[1]=1, o_ac[1]=7; diffs -5 and 2 -> o_ph[1]=-2.
REQ-032 Sequence: beats ch0,ch1,ch3 -> err_seq pulse on ch3, no frame_done; then ch0..ch3 -> normal frame_done.
REQ-033 Backpressure: o_rdy low 5 cycles on beat 1 -> outputs stable; i_rdy stays low until o_last completes.
REQ-034 Reset asserted in OUTPUT after beat 1 -> o_vld 0 at once; next full frame yields results of that frame only.
